fir_seq_filter: RTL and testbench

FIR_SEQ_FILTER -- requirements
Module: fir_seq_filter

---
 rtl/fir_seq_filter.sv | 167 ++++++++++++++++
 tb/tb_fir_seq_filter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_seq_filter.sv
// fir_seq_filter -- sequential symmetric FIR filter.
//
// Each accepted sample is shifted into a TAPS-deep delay line. The block then
// spends M+1 cycles (M = (TAPS-1)/2) adding one symmetric term per cycle into
// the accumulator. One OUTPUT cycle follows, which shifts, clamps and registers
// the result. A new sample is accepted only while the FSM sits in IDLE.
//
// Timing, counting from the edge that accepts a sample:
//   - in_ready is low for M+2 cycles.
//   - out_valid is high for one cycle, starting M+2 edges after acceptance.
//
// Optional feature:
//   FIR_ROUND_EN  when defined, 2^(SHIFT-1) is added before the right shift
//                 (round half up); otherwise the result is truncated.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous, active-high reset
//   in_valid     input sample valid
//   in_ready     high in IDLE only
//   in_data      input sample (unsigned, DW bits)
//   coef_we      coefficient write strobe; honoured only in IDLE
//   coef_addr    coefficient index 0..M; larger indices are ignored
//   coef_data    coefficient value (unsigned, CW bits)
//   out_valid    one-cycle result strobe
//   out_data     filtered result; holds until the next result
//   sat          result was clamped to 2^DW-1 (meaningful with out_valid)
//   dbg_state_o  current FSM state (0 IDLE, 1 ACCUM, 2 OUTPUT)
//
// Handshake: a sample transfers on a rising edge where in_valid and in_ready
// are both high. The source must hold in_data stable while in_valid is high
// and in_ready is low.
module fir_seq_filter #(
    parameter int DW    = 10,
    parameter int TAPS  = 31,
    parameter int CW    = 8,
    parameter int SHIFT = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          coef_we,
    input  logic [5:0]    coef_addr,
    input  logic [CW-1:0] coef_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          sat,
    output logic [1:0]    dbg_state_o
);

    localparam int M  = (TAPS - 1) / 2;
    // Pre-add is DW+1 bits, so one product needs DW+1+CW bits.
    localparam int PW = DW + 1 + CW;
    // Summing M+1 products needs clog2(M+1) more bits.
    localparam int AW = PW + $clog2(M + 1);
    localparam logic [5:0] M_ADDR = 6'(M);
    localparam logic [AW:0] MAX_C = {{(AW + 1 - DW){1'b0}}, {DW{1'b1}}};

`ifdef FIR_ROUND_EN
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [AW:0] RND_C = (SHIFT > 0) ? ({{AW{1'b0}}, 1'b1} << RND_SH) : '0;
`else
    localparam logic [AW:0] RND_C = '0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    state_t        state_q;
    logic [DW-1:0] dline_q [TAPS];
    logic [CW-1:0] coef_q  [M+1];
    logic [AW-1:0] acc_q;
    logic [5:0]    idx_q;
    logic          out_valid_q;
    logic [DW-1:0] out_data_q;
    logic          sat_q;

    logic [PW-1:0] term_d;
    logic [AW:0]   rnd_d;
    logic [AW:0]   shifted_d;
    logic          sat_d;
    logic [DW-1:0] data_d;

    // Term for the current index. Index k < M folds the two taps that share
    // c[k]. Index M is the lone centre tap. The index is compared with
    // constants so that every array select is static.
    always_comb begin
        term_d = '0;
        for (int k = 0; k <= M; k++) begin
            if (idx_q == 6'(k)) begin
                if (k < M) begin
                    term_d = PW'(coef_q[k]) * (PW'(dline_q[k]) + PW'(dline_q[TAPS-1-k]));
                end else begin
                    term_d = PW'(coef_q[k]) * PW'(dline_q[k]);
                end
            end
        end
    end

    // Output shaping: an optional rounding offset, then the shift, then a clamp
    // to the DW-bit range. One spare bit keeps the rounding add from wrapping.
    always_comb begin
        rnd_d     = {1'b0, acc_q} + RND_C;
        shifted_d = rnd_d >> SHIFT;
        sat_d     = (shifted_d > MAX_C);
        data_d    = sat_d ? {DW{1'b1}} : shifted_d[DW-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_q       <= 1'b0;
            for (int t = 0; t < TAPS; t++) dline_q[t] <= '0;
            for (int k = 0; k <= M; k++)   coef_q[k]  <= '0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A write and an accepted sample may share this edge. The
                    // new coefficient is already in place for the first ACCUM
                    // cycle, so it applies to this sample.
                    for (int k = 0; k <= M; k++) begin
                        if (coef_we && coef_addr == 6'(k)) coef_q[k] <= coef_data;
                    end
                    if (in_valid) begin
                        for (int t = 0; t < TAPS - 1; t++) dline_q[t] <= dline_q[t+1];
                        dline_q[TAPS-1] <= in_data;
                        acc_q   <= '0;
                        idx_q   <= '0;
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc_q <= acc_q + AW'(term_d);
                    if (idx_q == M_ADDR) begin
                        state_q <= OUTPUT;
                    end else begin
                        idx_q <= idx_q + 6'd1;
                    end
                end
                OUTPUT: begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= data_d;
                    sat_q       <= sat_d;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign sat         = sat_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fir_seq_filter.sv
// Testbench for fir_seq_filter.
//
// Two instances receive identical stimulus:
//   dut   default parameters (SHIFT = 10)
//   dut0  SHIFT = 0
//
// The reference model keeps the sample history and the full 31-tap impulse
// response. It computes each result as a direct convolution, then shifts and
// clamps it, and queues the result with the cycle on which it must appear.
module tb_fir_seq_filter;
    localparam int DW   = 10;
    localparam int TAPS = 31;
    localparam int CW   = 8;
    localparam int M    = (TAPS - 1) / 2;

`ifdef FIR_ROUND_EN
    localparam int EXP_DC = 1004;
`else
    localparam int EXP_DC = 1003;
`endif

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          coef_we;
    logic [5:0]    coef_addr;
    logic [CW-1:0] coef_data;

    logic          in_ready,  out_valid,  sat;
    logic [DW-1:0] out_data;
    logic [1:0]    dbg_state;

    logic          in_ready0, out_valid0, sat0;
    logic [DW-1:0] out_data0;
    logic [1:0]    dbg_state0;

    fir_seq_filter #(.DW(DW), .TAPS(TAPS), .CW(CW), .SHIFT(10)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .out_valid(out_valid), .out_data(out_data),
        .sat(sat), .dbg_state_o(dbg_state)
    );

    fir_seq_filter #(.DW(DW), .TAPS(TAPS), .CW(CW), .SHIFT(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .out_valid(out_valid0), .out_data(out_data0),
        .sat(sat0), .dbg_state_o(dbg_state0)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int          due;
        logic [DW:0] r;   // {sat, data} for SHIFT = 10
        logic [DW:0] r0;  // {sat, data} for SHIFT = 0
    } exp_t;

    exp_t        exp_q[$];
    logic [DW:0] cap_q[$];
    logic [DW:0] cap0_q[$];
    int          hist[TAPS];
    int          cmod[M+1];
    int          busy;
    int          low_run;
    logic [DW:0] last_r, last_r0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Full impulse response h[t] = c[min(t, TAPS-1-t)], applied as a plain
    // convolution over the stored history.
    function automatic longint conv();
        longint s = 0;
        for (int t = 0; t < TAPS; t++) begin
            int ci = (t <= TAPS - 1 - t) ? t : TAPS - 1 - t;
            s += longint'(cmod[ci]) * longint'(hist[t]);
        end
        return s;
    endfunction

    function automatic logic [DW:0] shape(input longint acc, input int sh);
        longint r = acc;
`ifdef FIR_ROUND_EN
        if (sh > 0) r = r + (longint'(1) << (sh - 1));
`endif
        r = r >> sh;
        if (r > 1023) return {1'b1, 10'h3FF};
        return {1'b0, DW'(r)};
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            check("rst_in_ready",  int'(in_ready),   1);
            check("rst_out_valid", int'(out_valid),  0);
            check("rst_out_data",  int'(out_data),   0);
            check("rst_sat",       int'(sat),        0);
            check("rst_out_valid0", int'(out_valid0), 0);
            check("rst_out_data0", int'(out_data0),  0);
            for (int t = 0; t < TAPS; t++) hist[t] = 0;
            for (int k = 0; k <= M; k++) cmod[k] = 0;
            exp_q.delete();
            busy    = 0;
            low_run = 0;
            last_r  = '0;
            last_r0 = '0;
        end else begin
            if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
                check("out_valid",  int'(out_valid),  1);
                check("out_data",   int'(out_data),   int'(exp_q[0].r[DW-1:0]));
                check("sat",        int'(sat),        int'(exp_q[0].r[DW]));
                check("out_valid0", int'(out_valid0), 1);
                check("out_data0",  int'(out_data0),  int'(exp_q[0].r0[DW-1:0]));
                check("sat0",       int'(sat0),       int'(exp_q[0].r0[DW]));
                last_r  = exp_q[0].r;
                last_r0 = exp_q[0].r0;
                cap_q.push_back({sat, out_data});
                cap0_q.push_back({sat0, out_data0});
                void'(exp_q.pop_front());
            end else begin
                check("no_out_valid",  int'(out_valid),  0);
                check("no_out_valid0", int'(out_valid0), 0);
                check("out_data_hold", int'(out_data),   int'(last_r[DW-1:0]));
                check("out_data_hold0", int'(out_data0), int'(last_r0[DW-1:0]));
                if (out_valid) cap_q.push_back({sat, out_data});
                if (out_valid0) cap0_q.push_back({sat0, out_data0});
            end

            check("in_ready",  int'(in_ready),  (busy == 0) ? 1 : 0);
            check("in_ready0", int'(in_ready0), (busy == 0) ? 1 : 0);

            if (in_ready) begin
                if (low_run > 0) check("ready_low_run", low_run, 17);
                low_run = 0;
            end else begin
                low_run++;
            end

            // Events at the coming rising edge, as the model sees them.
            if (busy == 0) begin
                if (coef_we && int'(coef_addr) <= M) cmod[int'(coef_addr)] = int'(coef_data);
                if (in_valid) begin
                    exp_t e;
                    longint acc;
                    for (int t = 0; t < TAPS - 1; t++) hist[t] = hist[t+1];
                    hist[TAPS-1] = int'(in_data);
                    acc   = conv();
                    e.due = cyc + 18;
                    e.r   = shape(acc, 10);
                    e.r0  = shape(acc, 0);
                    exp_q.push_back(e);
                    busy = 17;
                end
            end else begin
                busy--;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (22) tick();
    endtask

    task automatic send(input logic [DW-1:0] d, input bit keep);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("send_accepted", int'(ok), 1);
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic write_coef(input int a, input int d);
        coef_we   = 1'b1;
        coef_addr = 6'(a);
        coef_data = CW'(d);
        tick();
        coef_we = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    int          cset[M+1];
    bit          pend;
    logic [DW:0] got;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #3;
        check("init_in_ready",  int'(in_ready),  1);
        check("init_out_valid", int'(out_valid), 0);
        check("init_out_data",  int'(out_data),  0);
        check("init_sat",       int'(sat),       0);
        tick();

        // Coefficients k+1. A write during ACCUM must be dropped, and so must
        // a write to an address beyond M.
        for (int k = 0; k <= M; k++) write_coef(k, k + 1);
        write_coef(20, 200);
        send(0, 1'b0);
        repeat (2) tick();
        write_coef(0, 99);
        drain();

        // Impulse with valid held high; dut0 has SHIFT = 0.
        cap0_q.delete();
        for (int j = 0; j < TAPS; j++) send((j == 0) ? 10'd1 : 10'd0, j < TAPS - 1);
        drain();
        check("impulse_count", cap0_q.size(), TAPS);
        for (int j = 0; j < TAPS; j++) begin
            got = (j < cap0_q.size()) ? cap0_q[j] : '1;
            check("impulse", int'(got), (j <= M) ? j + 1 : TAPS - j);
        end

        // DC response, then saturation.
        cset = '{3, 4, 6, 8, 12, 17, 23, 29, 36, 43, 50, 56, 61, 65, 67, 68};
        for (int k = 0; k <= M; k++) write_coef(k, cset[k]);
        cap_q.delete();
        for (int j = 0; j < TAPS; j++) send(10'd1000, j < TAPS - 1);
        drain();
        got = (cap_q.size() == TAPS) ? cap_q[TAPS-1] : '1;
        check("dc_data", int'(got[DW-1:0]), EXP_DC);
        check("dc_sat",  int'(got[DW]),     0);
        cap_q.delete();
        for (int j = 0; j < TAPS; j++) send(10'd1023, j < TAPS - 1);
        drain();
        got = (cap_q.size() == TAPS) ? cap_q[TAPS-1] : '0;
        check("sat_data", int'(got[DW-1:0]), 1023);
        check("sat_flag", int'(got[DW]),     1);

        // Reset at the 5th ACCUM cycle: no result, and clean state afterwards.
        cap_q.delete();
        cap0_q.delete();
        send(10'd500, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        check("midrst_in_ready",  int'(in_ready),  1);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_data",  int'(out_data),  0);
        check("midrst_sat",       int'(sat),       0);
        tick();
        reset = 1'b0;
        repeat (25) tick();
        check("midrst_no_result", cap_q.size() + cap0_q.size(), 0);
        for (int k = 0; k <= M; k++) write_coef(k, k + 1);
        cap0_q.delete();
        send(10'd1, 1'b0);
        drain();
        got = (cap0_q.size() == 1) ? cap0_q[0] : '1;
        check("post_rst_first", int'(got), 1);

        // Randomized traffic, first with small then with full-range coefficients.
        for (int phase = 0; phase < 2; phase++) begin
            for (int k = 0; k <= M; k++)
                write_coef(k, (phase == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 255)));
            pend = 1'b0;
            for (int n = 0; n < 1500; n++) begin
                if (!pend && $urandom_range(0, 3) == 0) begin
                    pend    = 1'b1;
                    in_data = DW'($urandom_range(0, 1023));
                end
                in_valid  = pend;
                coef_we   = ($urandom_range(0, 9) == 0);
                coef_addr = 6'($urandom_range(0, 19));
                coef_data = CW'($urandom_range(0, (phase == 0) ? 40 : 255));
                @(negedge clk);
                if (in_valid && in_ready) pend = 1'b0;
                tick();
            end
            in_valid = 1'b0;
            coef_we  = 1'b0;
            drain();
        end
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
